// File: rtl/gcn_ctrl_pkg.sv
// Shared types for the GCN inference stage controller: FSM states, stage codes
// and the default per-stage timeout.
package gcn_ctrl_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_TRANSFORM,
        ST_COMBINE,
        ST_ARGMAX,
        ST_DONE,
        ST_ERROR
    } ctrl_state_e;

    typedef enum logic [1:0] {
        STG_NONE   = 2'd0,
        STG_TRANS  = 2'd1,
        STG_COMB   = 2'd2,
        STG_ARGMAX = 2'd3
    } stage_code_e;

    // Reported stage for a timeout raised while in state s.
    function automatic stage_code_e stage_code(input ctrl_state_e s);
        case (s)
            ST_TRANSFORM: return STG_TRANS;
            ST_COMBINE:   return STG_COMB;
            ST_ARGMAX:    return STG_ARGMAX;
            default:      return STG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gcn_stage_timer.sv
// Per-stage dwell counter: cleared on stage entry, counts cycles spent in the
// stage and flags the last permitted cycle.
module gcn_stage_timer
    import gcn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q, count_d;

    // Holding at LAST keeps the counter from wrapping if the stage lingers.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/gcn_stage_controller.sv
// Sequences one GCN inference run through transform, combine and argmax stages,
// with per-stage timeout, run cycle counter and ack handshake.
module gcn_stage_controller
    import gcn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ack,
    input  logic                 done_trans,
    input  logic                 done_comb,
    input  logic                 done_argmax,
    output logic                 stage_reset,
    output logic                 en_trans,
    output logic                 en_comb,
    output logic                 en_argmax,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           error_stage,
    output logic [CNT_WIDTH-1:0] total_cycles
);

    ctrl_state_e          state_q, state_d;
    stage_code_e          error_stage_q, error_stage_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic                 stage_reset_q, en_trans_q, en_comb_q, en_argmax_q;
    logic                 busy_q, done_q, error_q;
    logic                 in_stage, timer_clear, timer_expired;

    assign in_stage    = (state_q inside {ST_TRANSFORM, ST_COMBINE, ST_ARGMAX});
    assign timer_clear = (state_d != state_q);

    gcn_stage_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (timer_clear),
        .inc_i    (in_stage),
        .expired_o(timer_expired)
    );

    // A stage's done level always takes priority over its timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_TRANSFORM;
            ST_TRANSFORM: begin
                if (done_trans)         state_d = ST_COMBINE;
                else if (timer_expired) state_d = ST_ERROR;
            end
            ST_COMBINE: begin
                if (done_comb)          state_d = ST_ARGMAX;
                else if (timer_expired) state_d = ST_ERROR;
            end
            ST_ARGMAX: begin
                if (done_argmax)        state_d = ST_DONE;
                else if (timer_expired) state_d = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        total_d = total_q;
        if (state_d == ST_CLEAR) begin
            total_d = '0;
        end else if (in_stage && (total_q != '1)) begin
            total_d = total_q + 1'b1;
        end
    end

    always_comb begin
        error_stage_d = STG_NONE;
        if (state_d == ST_ERROR) begin
            error_stage_d = (state_q == ST_ERROR) ? error_stage_q : stage_code(state_q);
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            error_stage_q <= STG_NONE;
            total_q       <= '0;
            stage_reset_q <= 1'b0;
            en_trans_q    <= 1'b0;
            en_comb_q     <= 1'b0;
            en_argmax_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            error_stage_q <= error_stage_d;
            total_q       <= total_d;
            stage_reset_q <= (state_d == ST_CLEAR);
            en_trans_q    <= (state_d inside {ST_TRANSFORM, ST_COMBINE, ST_ARGMAX, ST_DONE});
            en_comb_q     <= (state_d inside {ST_COMBINE, ST_ARGMAX, ST_DONE});
            en_argmax_q   <= (state_d inside {ST_ARGMAX, ST_DONE});
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
            error_q       <= (state_d == ST_ERROR);
        end
    end

    assign stage_reset  = stage_reset_q;
    assign en_trans     = en_trans_q;
    assign en_comb      = en_comb_q;
    assign en_argmax    = en_argmax_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign error_stage  = error_stage_q;
    assign total_cycles = total_q;

endmodule

// File: tb/tb_gcn_stage_controller.sv
// Self-checking bench for gcn_stage_controller: a stage-index reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_gcn_stage_controller;

    localparam int T    = 16;
    localparam int CW   = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, ack;
    logic          done_trans, done_comb, done_argmax;
    logic          stage_reset, en_trans, en_comb, en_argmax, busy, done, error;
    logic [1:0]    error_stage;
    logic [CW-1:0] total_cycles;

    gcn_stage_controller #(
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ack         (ack),
        .done_trans  (done_trans),
        .done_comb   (done_comb),
        .done_argmax (done_argmax),
        .stage_reset (stage_reset),
        .en_trans    (en_trans),
        .en_comb     (en_comb),
        .en_argmax   (en_argmax),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_stage (error_stage),
        .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    int total_n = 0;
    int bad_n   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Datapath responder: done level rises dly cycles after its enable and
    // stays up while enabled; dly<0 means it never rises.
    int dly_t = -1, dly_c = -1, dly_a = -1;
    bit pre_t = 0;
    int cnt_t = 0, cnt_c = 0, cnt_a = 0;
    always @(negedge clk) begin
        cnt_t = en_trans  ? cnt_t + 1 : 0;
        cnt_c = en_comb   ? cnt_c + 1 : 0;
        cnt_a = en_argmax ? cnt_a + 1 : 0;
        done_trans  = pre_t || (dly_t >= 0 && cnt_t > dly_t);
        done_comb   = (dly_c >= 0 && cnt_c > dly_c);
        done_argmax = (dly_a >= 0 && cnt_a > dly_a);
    end

    int sr_count = 0, trans_cycles = 0, comb_cycles = 0;
    always @(negedge clk) begin
        if (stage_reset) sr_count++;
        if (en_trans && !en_comb) trans_cycles++;
        if (en_comb && !en_argmax) comb_cycles++;
    end

    // Reference model: stage index 0 idle, 1 clear, 2..4 work stages, 5 done, 6 error.
    int m_stage = 0, m_dwell = 0, m_total = 0, m_err = 0, m_nxt;
    bit [2:0] m_dv;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stage = 0; m_dwell = 0; m_total = 0; m_err = 0;
        end else begin
            m_nxt = m_stage;
            m_dv  = {done_argmax, done_comb, done_trans};
            if (m_stage == 0) begin
                if (start) m_nxt = 1;
            end else if (m_stage == 1) begin
                m_nxt = 2;
            end else if (m_stage <= 4) begin
                m_total = (m_total < MAXC) ? m_total + 1 : MAXC;
                if (m_dv[m_stage-2]) m_nxt = m_stage + 1;
                else if (m_dwell == T - 1) begin
                    m_nxt = 6;
                    m_err = m_stage - 1;
                end
            end else if (ack) begin
                m_nxt = 0;
            end
            if (m_nxt == 1) m_total = 0;
            if (m_nxt != 6) m_err = 0;
            m_dwell = (m_nxt == m_stage) ? m_dwell + 1 : 0;
            m_stage = m_nxt;
        end
    end

    always @(negedge clk) begin
        chk("cmp_stage_reset", stage_reset, m_stage == 1);
        chk("cmp_en_trans",    en_trans,    m_stage >= 2 && m_stage <= 5);
        chk("cmp_en_comb",     en_comb,     m_stage >= 3 && m_stage <= 5);
        chk("cmp_en_argmax",   en_argmax,   m_stage >= 4 && m_stage <= 5);
        chk("cmp_busy",        busy,        m_stage != 0);
        chk("cmp_done",        done,        m_stage == 5);
        chk("cmp_error",       error,       m_stage == 6);
        chk("cmp_error_stage", error_stage, m_err);
        chk("cmp_total",       total_cycles, m_total);
    end

    task automatic wait_end(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1;
                break;
            end
        end
        chk("wait_end", ok, 1);
    endtask

    task automatic run_start(input int dt, input int dc, input int da);
        @(negedge clk);
        dly_t = dt; dly_c = dc; dly_a = da;
        sr_count = 0; trans_cycles = 0; comb_cycles = 0;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("ack_busy", busy, 0);
        chk("ack_error_stage", error_stage, 0);
        chk("ack_en_trans", en_trans, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; start = 0; ack = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {stage_reset, en_trans, en_comb, en_argmax, busy, done,
                              error, error_stage, total_cycles}, 0);
        reset = 0;

        // Nominal run: dones 5, 8, 6 cycles after each enable.
        run_start(5, 8, 6);
        wait_end(200);
        chk("nom_total", total_cycles, 22);
        chk("nom_done", done, 1);
        chk("nom_error", error, 0);
        chk("nom_stage_reset_pulses", sr_count, 1);
        do_ack();

        // Combine never finishes.
        run_start(5, -1, -1);
        wait_end(200);
        chk("to_error", error, 1);
        chk("to_error_stage", error_stage, 2);
        chk("to_comb_cycles", comb_cycles, 16);
        chk("to_total", total_cycles, 22);
        chk("to_done", done, 0);
        do_ack();

        // done_trans already high when TRANSFORM is entered.
        pre_t = 1;
        run_start(-1, 2, 0);
        wait_end(200);
        chk("pre_trans_cycles", trans_cycles, 1);
        chk("pre_total", total_cycles, 5);
        chk("pre_done", done, 1);
        do_ack();
        pre_t = 0;

        // Every done lands on its timeout cycle; counter saturates.
        run_start(15, 15, 15);
        wait_end(200);
        chk("edge_done", done, 1);
        chk("edge_error", error, 0);
        chk("edge_trans_cycles", trans_cycles, 16);
        chk("edge_total_sat", total_cycles, MAXC);
        do_ack();

        // Reset in the middle of COMBINE.
        run_start(2, -1, -1);
        begin
            bit ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (en_comb) begin
                    ok = 1;
                    break;
                end
            end
            chk("reach_comb", ok, 1);
        end
        repeat (3) @(negedge clk);
        #1 reset = 1;
        #1 chk("midreset_outputs", {stage_reset, en_trans, en_comb, en_argmax, busy, done,
                                    error, error_stage, total_cycles}, 0);
        @(negedge clk);
        reset = 0;
        chk("midreset_sr_pulses", sr_count, 1);
        run_start(1, 1, 1);
        wait_end(200);
        chk("post_reset_done", done, 1);
        chk("post_reset_total", total_cycles, 6);
        do_ack();

        // start held high throughout, including the ack cycle.
        @(negedge clk);
        dly_t = 1; dly_c = 1; dly_a = 1;
        sr_count = 0;
        start = 1;
        wait_end(200);
        @(negedge clk);
        ack = 1;
        @(negedge clk);
        ack = 0; start = 0;
        chk("hold_busy_after_ack", busy, 0);
        repeat (3) @(negedge clk);
        chk("hold_stays_idle", busy, 0);
        chk("hold_single_run", sr_count, 1);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
